// File: rtl/operand2_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : operand2_shift_sequencer
//  Description : Multi-cycle operand-2 generator for the EXE stage; applies
//                LSL/LSR/ASR/ROR shifts at most STEP bits per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand2_shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             imm,
    input  logic             is_mem_related,
    input  logic [WIDTH-1:0] val_r_m,
    input  logic [WIDTH-1:0] val_r_s,
    input  logic [11:0]      shift_operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] val_2
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int ROT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] c_width_cnt = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_step_cnt  = CNT_W'(STEP);

    localparam logic [1:0] c_kind_lsl = 2'b00;
    localparam logic [1:0] c_kind_lsr = 2'b01;
    localparam logic [1:0] c_kind_asr = 2'b10;
    localparam logic [1:0] c_kind_ror = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;
    logic [1:0]       r_kind;
    logic [1:0]       w_kind_next;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_rem_next;
    logic [WIDTH-1:0] r_val_2;
    logic             w_load;

    logic [7:0]       w_amt;
    logic [1:0]       w_dec_kind;
    logic [WIDTH-1:0] w_dec_acc;
    logic [CNT_W-1:0] w_dec_count;

    logic [CNT_W-1:0] w_step;
    logic [WIDTH-1:0] w_shifted;

    // Operand decode, only consumed on the cycle a start is accepted
    always_comb begin
        w_amt       = '0;
        w_dec_kind  = c_kind_lsl;
        w_dec_acc   = '0;
        w_dec_count = '0;
        if (is_mem_related) begin
            w_dec_acc = {{(WIDTH-12){1'b0}}, shift_operand};
        end else if (imm) begin
            w_dec_acc  = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
            w_dec_kind = c_kind_ror;
            w_amt      = {3'b000, shift_operand[11:8], 1'b0};
        end else begin
            w_dec_acc  = val_r_m;
            w_dec_kind = shift_operand[6:5];
            w_amt      = shift_operand[4] ? val_r_s[7:0] : {3'b000, shift_operand[11:7]};
        end

        // Rotations wrap modulo WIDTH; linear shifts saturate at WIDTH
        if (w_dec_kind == c_kind_ror) begin
            w_dec_count = CNT_W'(w_amt[ROT_W-1:0]);
        end else if ({1'b0, w_amt} >= 9'(WIDTH)) begin
            w_dec_count = c_width_cnt;
        end else begin
            w_dec_count = CNT_W'(w_amt);
        end
    end

    always_comb begin
        w_step    = (r_remaining < c_step_cnt) ? r_remaining : c_step_cnt;
        w_shifted = r_acc;
        case (r_kind)
            c_kind_lsl: w_shifted = r_acc << w_step;
            c_kind_lsr: w_shifted = r_acc >> w_step;
            c_kind_asr: w_shifted = $signed(r_acc) >>> w_step;
            c_kind_ror: w_shifted = (r_acc >> w_step) | (r_acc << (c_width_cnt - w_step));
            default:    w_shifted = r_acc;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_kind_next  = r_kind;
        w_rem_next   = r_remaining;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_acc_next  = w_dec_acc;
                    w_kind_next = w_dec_kind;
                    w_rem_next  = w_dec_count;
                    if (w_dec_count == '0) begin
                        w_state_next = DONE;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_acc_next = w_shifted;
                w_rem_next = r_remaining - w_step;
                if (w_rem_next == '0) begin
                    w_state_next = DONE;
                    w_load       = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_kind      <= c_kind_lsl;
            r_remaining <= '0;
            r_val_2     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_kind      <= w_kind_next;
            r_remaining <= w_rem_next;
            // Result register only moves on entry to DONE, hiding partial shifts
            if (w_load) begin
                r_val_2 <= w_acc_next;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = (r_state == DONE);
    assign val_2 = r_val_2;

endmodule
`default_nettype wire

// File: tb/tb_operand2_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand2_shift_sequencer
//  Description : Directed self-checking bench for operand2_shift_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand2_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imm;
    logic        is_mem_related;
    logic [31:0] val_r_m;
    logic [31:0] val_r_s;
    logic [11:0] shift_operand;
    logic        busy;
    logic        done;
    logic [31:0] val_2;

    int errors = 0;
    int checks = 0;

    operand2_shift_sequencer #(.WIDTH(32), .STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imm            (imm),
        .is_mem_related (is_mem_related),
        .val_r_m        (val_r_m),
        .val_r_s        (val_r_s),
        .shift_operand  (shift_operand),
        .busy           (busy),
        .done           (done),
        .val_2          (val_2)
    );

    always #5 clk = ~clk;

    task automatic run_op(input string name, input logic [11:0] so, input logic [31:0] rm,
                          input logic [31:0] rs, input logic im, input logic mem,
                          input logic [31:0] exp_val, input int exp_cyc);
        logic [31:0] held;
        int          cyc;
        bit          stable;
        @(posedge clk); #1;
        held           = val_2;
        shift_operand  = so;
        val_r_m        = rm;
        val_r_s        = rs;
        imm            = im;
        is_mem_related = mem;
        start          = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cyc    = 1;
        stable = 1'b1;
        // scramble inputs while in flight; they must not matter
        val_r_m        = ~rm;
        val_r_s        = 32'h0000_0003;
        shift_operand  = ~so;
        imm            = ~im;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_c1: got %b want 1", name, busy);
        end
        while (done !== 1'b1 && cyc < 60) begin
            if (val_2 !== held) stable = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s latency: got cycle %0d want %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (val_2 !== exp_val) begin
            errors++;
            $display("FAIL %s val_2: got %h want %h", name, val_2, exp_val);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL %s val_2_hold: changed before done (held %h)", name, held);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: busy=%b done=%b want 0 0", name, busy, done);
        end
        is_mem_related = 1'b0;
        imm            = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || val_2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b val_2=%h want 0 0 0", busy, done, val_2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_imm;
        run_op("imm_ror8",  12'h4FF, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFF00_0000, 3);
        run_op("imm_ror2",  12'h1F0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_003C, 2);
    endtask

    task automatic test_mem;
        run_op("mem_over_imm", 12'hABC, 32'h5555_5555, 32'h0, 1'b1, 1'b1, 32'h0000_0ABC, 1);
        run_op("mem_only",     12'h123, 32'h5555_5555, 32'h0, 1'b0, 1'b1, 32'h0000_0123, 1);
    endtask

    task automatic test_reg_shift;
        run_op("asr_i4",  12'h240, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 32'hF800_0001, 2);
        run_op("lsl_i3",  12'h180, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 32'h0000_0008, 2);
        run_op("lsr_i5",  12'h2A0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0400_0000, 3);
        run_op("ror_i0",  12'h060, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 32'hCAFE_F00D, 1);
    endtask

    task automatic test_rs_shift;
        run_op("lsr_rs40",  12'h030, 32'hFFFF_FFFF, 32'd40,  1'b0, 1'b0, 32'h0000_0000, 9);
        run_op("ror_rs36",  12'h070, 32'h1234_5678, 32'd36,  1'b0, 1'b0, 32'h8123_4567, 2);
        run_op("asr_rs32",  12'h050, 32'h8000_0000, 32'd32,  1'b0, 1'b0, 32'hFFFF_FFFF, 9);
        run_op("asr_rs255", 12'h050, 32'h7FFF_FFFF, 32'h1FF, 1'b0, 1'b0, 32'h0000_0000, 9);
        run_op("lsl_rs32",  12'h010, 32'hFFFF_FFFF, 32'd32,  1'b0, 1'b0, 32'h0000_0000, 9);
        run_op("lsr_rs4_b7",12'h0B0, 32'h0000_00F0, 32'd4,   1'b0, 1'b0, 32'h0000_000F, 2);
    endtask

    task automatic test_zero;
        run_op("lsl_i0", 12'h000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        shift_operand = 12'h000;
        val_r_m       = 32'hDEAD_BEEF;
        start         = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || val_2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL b2b_first: done=%b val_2=%h want 1 deadbeef", done, val_2);
        end
        val_r_m = 32'h1111_1111;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || val_2 !== 32'h1111_1111) begin
            errors++;
            $display("FAIL b2b_second: done=%b val_2=%h want 1 11111111", done, val_2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy;
        int ndone;
        int dcyc;
        ndone = 0;
        dcyc  = -1;
        @(posedge clk); #1;
        shift_operand = 12'h030;
        val_r_s       = 32'd32;
        val_r_m       = 32'hFFFF_FFFF;
        start         = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                dcyc = c;
            end
            start = (c == 3 || c == 5 || c == 9);
        end
        start = 1'b0;
        checks++;
        if (ndone != 1 || dcyc != 9) begin
            errors++;
            $display("FAIL busy_start: got %0d dones (last cycle %0d) want 1 at 9", ndone, dcyc);
        end
    endtask

    task automatic test_reset_mid;
        int ndone;
        bit any_busy;
        run_op("pre_reset", 12'h000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
        @(posedge clk); #1;
        shift_operand = 12'h030;
        val_r_s       = 32'd32;
        val_r_m       = 32'hFFFF_FFFF;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || val_2 !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b val_2=%h want 0 0 0", busy, done, val_2);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        ndone    = 0;
        any_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
            if (busy !== 1'b0) any_busy = 1'b1;
        end
        checks++;
        if (ndone != 0 || any_busy) begin
            errors++;
            $display("FAIL post_reset: dones=%0d busy_seen=%b want 0 0", ndone, any_busy);
        end
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        imm            = 1'b0;
        is_mem_related = 1'b0;
        val_r_m        = '0;
        val_r_s        = '0;
        shift_operand  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_imm;
        test_mem;
        test_reg_shift;
        test_rs_shift;
        test_zero;
        test_back_to_back;
        test_start_while_busy;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
